// File: rtl/ppu_exchange_sequencer.sv
// ============================================================================
// Module   : ppu_exchange_sequencer
// Brief    : Collects neighbor partial sums and forwards them to the partial
//            buffer one at a time, then sequences the exchange/accumulate phases.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ppu_exchange_sequencer #(
    parameter int NEIGHBOR_COUNT = 8,
    parameter int TILE_SIZE      = 256,
    parameter int BANK_COUNT     = 256,
    parameter int BUFFER_WIDTH   = 256,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      bitwidth,
    input  logic                            channel_group_done,
    input  logic                            nbr_in_valid  [NEIGHBOR_COUNT],
    input  logic [$clog2(TILE_SIZE)-1:0]    nbr_in_row    [NEIGHBOR_COUNT],
    input  logic [$clog2(TILE_SIZE)-1:0]    nbr_in_column [NEIGHBOR_COUNT],
    input  logic [DATA_WIDTH-1:0]           nbr_in_data   [NEIGHBOR_COUNT],
    output logic                            nbr_in_ready  [NEIGHBOR_COUNT],
    input  logic [NEIGHBOR_COUNT-1:0]       nbr_exchange_done,
    output logic                            buf_wr_valid,
    output logic [$clog2(TILE_SIZE)-1:0]    buf_wr_row,
    output logic [$clog2(TILE_SIZE)-1:0]    buf_wr_column,
    output logic [DATA_WIDTH-1:0]           buf_wr_data,
    input  logic [$clog2(BANK_COUNT)-1:0]   partial_rd_bank,
    input  logic [$clog2(BUFFER_WIDTH)-1:0] partial_rd_entry,
    input  logic [$clog2(BANK_COUNT)-1:0]   acc_rd_bank,
    input  logic [$clog2(BUFFER_WIDTH)-1:0] acc_rd_entry,
    input  logic                            acc_done,
    output logic [$clog2(BANK_COUNT)-1:0]   buf_rd_bank,
    output logic [$clog2(BUFFER_WIDTH)-1:0] buf_rd_entry,
    output logic [1:0]                      phase,
    output logic                            clear_to_send,
    output logic                            cycle_done,
    output logic                            protocol_error
);

    localparam int RW = $clog2(TILE_SIZE);
    localparam int IW = (NEIGHBOR_COUNT > 1) ? $clog2(NEIGHBOR_COUNT) : 1;

    typedef enum logic [1:0] {
        PH_IDLE       = 2'd0,
        PH_EXCHANGE   = 2'd1,
        PH_DRAIN      = 2'd2,
        PH_ACCUMULATE = 2'd3
    } phase_t;

    phase_t                    phase_q;
    logic [NEIGHBOR_COUNT-1:0] hold_valid_q;
    logic [RW-1:0]             hold_row_q  [NEIGHBOR_COUNT];
    logic [RW-1:0]             hold_col_q  [NEIGHBOR_COUNT];
    logic [DATA_WIDTH-1:0]     hold_data_q [NEIGHBOR_COUNT];
    logic [IW-1:0]             ptr_q;
    logic [IW-1:0]             ptr_d;
    logic                      wr_valid_q;
    logic [RW-1:0]             wr_row_q;
    logic [RW-1:0]             wr_col_q;
    logic [DATA_WIDTH-1:0]     wr_data_q;
    logic                      cycle_done_q;
    logic                      perr_q;

    logic                      grant_any;
    logic [IW-1:0]             grant_idx;
    logic [IW-1:0]             scan_idx;

    // Precision is applied at capture so a later bitwidth change cannot alter held data.
    function automatic logic [DATA_WIDTH-1:0] sext(input logic [1:0] bw,
                                                   input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        case (bw)
            2'd0:    r = DATA_WIDTH'($signed(d[1:0]));
            2'd1:    r = DATA_WIDTH'($signed(d[3:0]));
            2'd2:    r = DATA_WIDTH'($signed(d[7:0]));
            default: r = DATA_WIDTH'($signed(d[15:0]));
        endcase
        return r;
    endfunction

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NEIGHBOR_COUNT; k++) begin
            scan_idx = IW'((int'(ptr_q) + k) % NEIGHBOR_COUNT);
            if (!grant_any && hold_valid_q[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        ptr_d = (grant_idx == IW'(NEIGHBOR_COUNT - 1)) ? '0 : grant_idx + IW'(1);
    end

    for (genvar i = 0; i < NEIGHBOR_COUNT; i++) begin : g_ready
        assign nbr_in_ready[i] = !hold_valid_q[i] && (phase_q != PH_ACCUMULATE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= '0;
            for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
                hold_row_q[i]  <= '0;
                hold_col_q[i]  <= '0;
                hold_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
                if (grant_any && (grant_idx == IW'(i))) begin
                    hold_valid_q[i] <= 1'b0;
                end else if (nbr_in_valid[i] && nbr_in_ready[i]) begin
                    hold_valid_q[i] <= 1'b1;
                    hold_row_q[i]   <= nbr_in_row[i];
                    hold_col_q[i]   <= nbr_in_column[i];
                    hold_data_q[i]  <= sext(bitwidth, nbr_in_data[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= PH_IDLE;
            ptr_q        <= '0;
            wr_valid_q   <= 1'b0;
            wr_row_q     <= '0;
            wr_col_q     <= '0;
            wr_data_q    <= '0;
            cycle_done_q <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            wr_valid_q   <= grant_any;
            cycle_done_q <= 1'b0;
            if (grant_any) begin
                wr_row_q  <= hold_row_q[grant_idx];
                wr_col_q  <= hold_col_q[grant_idx];
                wr_data_q <= hold_data_q[grant_idx];
                ptr_q     <= ptr_d;
            end
            if ((channel_group_done && phase_q != PH_IDLE) ||
                (acc_done && phase_q != PH_ACCUMULATE)) begin
                perr_q <= 1'b1;
            end
            case (phase_q)
                PH_IDLE:
                    if (channel_group_done) phase_q <= PH_EXCHANGE;
                PH_EXCHANGE:
                    if (&nbr_exchange_done) phase_q <= PH_DRAIN;
                PH_DRAIN:
                    if (!(|hold_valid_q) && !wr_valid_q) phase_q <= PH_ACCUMULATE;
                default:
                    if (acc_done) begin
                        phase_q      <= PH_IDLE;
                        cycle_done_q <= 1'b1;
                    end
            endcase
        end
    end

    assign buf_rd_bank    = (phase_q == PH_ACCUMULATE) ? acc_rd_bank  : partial_rd_bank;
    assign buf_rd_entry   = (phase_q == PH_ACCUMULATE) ? acc_rd_entry : partial_rd_entry;
    assign buf_wr_valid   = wr_valid_q;
    assign buf_wr_row     = wr_row_q;
    assign buf_wr_column  = wr_col_q;
    assign buf_wr_data    = wr_data_q;
    assign phase          = phase_q;
    assign clear_to_send  = ~|hold_valid_q;
    assign cycle_done     = cycle_done_q;
    assign protocol_error = perr_q;

endmodule

`default_nettype wire
